dt2_regfile: RTL
================

DT2_REGFILE -- requirements
Module: dt2_regfile

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREG, default 32, register count; power of two, minimum 4; AW = clog2(NREG).
REQ-003 Parameter NRD, default 2, number of independent read ports.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 we  in  1  write enable; wa  in  AW  write address; wd  in  XLEN  write data.
REQ-007 ra  in  NRD*AW  packed read addresses, port k at bits [k*AW +: AW].
REQ-008 rd  out  NRD*XLEN  packed read data, port k at bits [k*XLEN +: XLEN].
REQ-009 rbusy  out  NRD  scoreboard pending bit for each ra[k].
REQ-010 sb_set  in  1 and sb_addr  in  AW  mark a register as pending a write.
REQ-011 clr_req  in  1  request a sequential clear of all registers.
REQ-012 clr_busy  out  1  clear sweep in progress; clr_done  out  1  one-cycle completion pulse.

Function
REQ-013 Register 0 shall always read 0, shall ignore writes and shall never be busy.
REQ-014 Reads shall be combinational: rd[k] = rf[ra[k]]; a write becomes visible after the rising edge that performs it.
REQ-015 A write shall occur on the rising edge when we=1, wa!=0 and clr_busy=0; during a sweep, we is ignored.
REQ-016 Scoreboard: an edge with sb_set=1 shall set busy[sb_addr]; a performed write shall clear busy[wa].
REQ-017 If sb_set and a performed write target the same address on the same edge, the set shall win and busy stays 1.
REQ-018 rbusy[k] = busy[ra[k]], combinational, with 0 for address 0.
REQ-019 Clear FSM with states IDLE and CLEAR; IDLE goes to CLEAR on clr_req=1, which loads the index counter with 1.
REQ-020 In CLEAR, each edge shall write 0 to rf[idx], clear busy[idx] and increment idx; at idx=NREG-1, the FSM returns to IDLE after that write.
REQ-021 clr_busy shall equal (state==CLEAR); clr_done shall pulse high for exactly one cycle in the cycle after the last clear write.
REQ-022 clr_req while in CLEAR shall be ignored and shall not restart the sweep; a sweep takes exactly NREG-1 cycles.
REQ-023 sb_set during CLEAR shall be ignored.
REQ-024 Reads during CLEAR shall return the current, partially cleared contents.

Reset
REQ-025 rst_n=0 shall immediately zero every register, every busy bit and idx, and shall force the FSM to IDLE.
REQ-026 Output values during reset: rd all 0, rbusy 0, clr_busy 0, clr_done 0.
REQ-027 Reset asserted mid-sweep shall abort the sweep with no clr_done pulse.

Configuration
REQ-028 Macro DT2_REGFILE_BYPASS_EN. When defined, if a write is performed this cycle with wa==ra[k]!=0, rd[k] shall return wd and rbusy[k] shall return 0 (unless REQ-017 applies).
REQ-029 When DT2_REGFILE_BYPASS_EN is undefined, reads shall return only the stored contents and the scoreboard state, per REQ-014/018.

Structure
REQ-030 A shared package shall hold the default XLEN and NREG, the FSM state typedef (IDLE, CLEAR) and the register-0 address constant.
REQ-031 One sub-module, dt2_regfile_rdport (address mux plus optional bypass), shall be instantiated NRD times via generate.

Verification
REQ-032 Write x5=0xDEADBEEF, then read ra0=5 and ra1=0 the next cycle: rd0=0xDEADBEEF and rd1=0.
REQ-033 Write x0=0x12345678: a subsequent read of x0 returns 0.
REQ-034 sb_set x7, then a write to x7 while a new sb_set x7 occurs on the same edge: rbusy stays 1. A later write to x7 alone clears it.
REQ-035 With BYPASS_EN, we=1, wa=3, wd=0xA5A5A5A5 and ra0=3 in the same cycle: rd0=0xA5A5A5A5 before the edge. Without it, rd0 shows the old value.
REQ-036 Fill all registers, pulse clr_req, and pulse it again mid-sweep: clr_busy is high for exactly NREG-1 cycles, we is ignored, clr_done pulses once, and all registers read 0.
REQ-037 Drop rst_n asynchronously mid-sweep and mid-cycle: all outputs go to 0 immediately, with no clr_done pulse.

Source files
------------

// File: rtl/dt2_regfile_pkg.sv
// Shared constants and types for the dt2_regfile register file.
// Default widths, clear-FSM state encoding and the hard-wired zero register address.
package dt2_regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/dt2_regfile_rdport.sv
// One read port: register/scoreboard address mux with an optional same-cycle write bypass.
// Bypass is compiled in when DT2_REGFILE_BYPASS_EN is defined.
module dt2_regfile_rdport #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [NREG*XLEN-1:0] rf_flat,
  input  logic [NREG-1:0]      busy,
  input  logic [AW-1:0]        ra,
  input  logic                 fwd_en,
  input  logic [AW-1:0]        wa,
  input  logic [XLEN-1:0]      wd,
  input  logic                 fwd_busy,
  output logic [XLEN-1:0]      rd,
  output logic                 rbusy
);

  logic [XLEN-1:0] regs [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_unpack
      assign regs[gi] = rf_flat[gi*XLEN +: XLEN];
    end
  endgenerate

`ifdef DT2_REGFILE_BYPASS_EN
  always_comb begin
    rd    = regs[ra];
    rbusy = busy[ra];
    // fwd_en already excludes address 0, sweeps and reset
    if (fwd_en && (wa == ra)) begin
      rd    = wd;
      rbusy = fwd_busy;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_en, wa, wd, fwd_busy};

  always_comb begin
    rd    = regs[ra];
    rbusy = busy[ra];
  end
`endif

endmodule

// File: rtl/dt2_regfile.sv
// Register file with x0 hard-wired to zero, a pending-write scoreboard and a sequential clear sweep.
// Optional write-to-read bypass on every port is enabled by defining DT2_REGFILE_BYPASS_EN.
module dt2_regfile
  import dt2_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

  clr_state_t state_reg, state_next;
  logic [AW-1:0]   idx_reg;
  logic            done_reg;
  logic            sweep_last;
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy_reg;
  logic [NREG*XLEN-1:0] rf_flat;
  logic            wr_en;
  logic            sb_en;
  logic            fwd_en;
  logic            fwd_busy;

  assign wr_en    = we && (wa != ZERO_ADDR) && !clr_busy;
  assign sb_en    = sb_set && (sb_addr != ZERO_ADDR) && !clr_busy;
  // rst_n gates the bypass so reads stay zero while reset is held
  assign fwd_en   = wr_en && rst_n;
  assign fwd_busy = sb_en && (sb_addr == wa);

  // Clear FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Clear FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (clr_req) state_next = CLEAR;
      CLEAR:   if (idx_reg == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    clr_busy   = (state_reg == CLEAR);
    sweep_last = (state_reg == CLEAR) && (idx_reg == LAST_IDX);
  end

  assign clr_done = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= sweep_last;
      if (state_reg == IDLE) begin
        if (clr_req) idx_reg <= AW'(1);
      end else begin
        idx_reg <= idx_reg + AW'(1);
      end
    end
  end

  // Storage and scoreboard; a scoreboard set is applied last so it wins over a write clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      busy_reg <= '0;
    end else begin
      if (wr_en) begin
        rf[wa]       <= wd;
        busy_reg[wa] <= 1'b0;
      end
      if (clr_busy) begin
        rf[idx_reg]       <= '0;
        busy_reg[idx_reg] <= 1'b0;
      end
      if (sb_en) busy_reg[sb_addr] <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_flat
      assign rf_flat[gi*XLEN +: XLEN] = rf[gi];
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rdport
      dt2_regfile_rdport #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
      ) u_rdport (
        .rf_flat  (rf_flat),
        .busy     (busy_reg),
        .ra       (ra[gi*AW +: AW]),
        .fwd_en   (fwd_en),
        .wa       (wa),
        .wd       (wd),
        .fwd_busy (fwd_busy),
        .rd       (rd[gi*XLEN +: XLEN]),
        .rbusy    (rbusy[gi])
      );
    end
  endgenerate

endmodule
